multi_pump_ctrl: RTL and testbench
==================================

# multi_pump_ctrl

Parametrised N-channel pump controller for the filter core: it takes per-channel duty commands over a valid/ready port and ramps each pump's PWM output toward its target. Each channel has a debounced level interlock that forces that pump off. It sits between the handshake/status decode logic and the pump driver pins, generalising the fixed two-pump arrangement to any channel count and PWM resolution.

## Interface
- `NUM_CH`, 2: number of pump channels (1–8)
- `PWM_WIDTH`, 8: duty/counter width in bits
- `DEBOUNCE_CYCLES`, 1_000_000: stable cycles needed before an interlock input change is accepted (20 ms @ 50 MHz)
- `RAMP_STEP_CYCLES`, 50_000: cycles between single-LSB duty steps during a ramp
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ch`  in  `$clog2(NUM_CH)` (min 1)  target channel
- `cmd_duty`  in  `PWM_WIDTH`  target duty
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_err`  out  1  one-cycle pulse: channel index out of range
- `stop_async`  in  `NUM_CH`  raw interlock per channel; 1 = must stop
- `pwm_out`  out  `NUM_CH`  pump PWM
- `lockout`  out  `NUM_CH`  channel is locked out by its interlock
- `duty_now`  out  `NUM_CH*PWM_WIDTH`  current applied duty; ch0 in the LSBs

## Operation
- Reset values: `cmd_ready`=0, `cmd_err`=0, `pwm_out`=0, `lockout`=0, `duty_now`=0, all targets 0, all channels IDLE. Debouncer outputs reset to 0 (not stopped).
- `cmd_ready`=1 in every non-reset cycle.
- Command accept (`cmd_valid` & `cmd_ready`):
  - `cmd_ch` < `NUM_CH`: write `cmd_duty` into that channel's target register.
  - `cmd_ch` ≥ `NUM_CH`: nothing is written; `cmd_err` pulses the next cycle.
- Per-channel FSM:
  - IDLE (duty=0). Goes to RAMP when target≠0.
  - RAMP: duty moves ±1 LSB each time the channel's step timer expires. Goes to RUN when duty==target.
  - RUN: holds duty. Goes to RAMP when the target changes. Goes to IDLE when target==0 and duty==0.
  - LOCKOUT: entered from any state when the debounced stop is 1. Duty is forced to 0 in the same cycle the debounced stop rises. Target is cleared to 0.
- Leaving LOCKOUT requires the debounced stop to be 0. The channel then goes to IDLE, and only a new command restarts the pump. A command accepted while locked out is discarded; the target stays 0.
- Simultaneous command and stop rise on the same channel: stop wins and the target is 0.
- PWM counter:
  - One counter shared by all channels, free-running 0 .. 2^`PWM_WIDTH`−2 (period 2^`PWM_WIDTH`−1 cycles), wraps to 0.
  - `pwm_out[i]` = (cnt < duty_i), registered.
  - Duty 0 gives a constant 0. Duty = all-ones gives a constant 1.
- Debounce: the raw input is synchronised through 2 flops. The output takes the new level only after it has been stable for `DEBOUNCE_CYCLES` consecutive cycles. Any glitch restarts the count.

## Timing
- Target register written 1 cycle after accept.
- Ramp ON: first duty step comes `RAMP_STEP_CYCLES` after the target write. Full-scale ramp 0→255 (8-bit) takes 255·`RAMP_STEP_CYCLES` cycles.
- Ramp OFF: duty_now equals target 1 cycle after the target write.
- `pwm_out` follows `duty_now` one cycle later. A duty change takes effect mid-period, with no wait for the counter to wrap.
- Interlock path: raw stop → sync (2) → debounce (`DEBOUNCE_CYCLES`) → `lockout` and duty=0 (+1) → `pwm_out`=0 (+1).
- Reset mid-ramp or mid-lockout returns everything to reset values on the next edge.

## Configuration
- `MULTI_PUMP_RAMP_EN` defined: RAMP state and per-channel step timers are present, as described above.
- Not defined: no RAMP state or step timers. duty_now takes the target 1 cycle after the target write, and the FSM goes directly IDLE↔RUN.

## Structure
- Package `multi_pump_pkg`:
  - channel state enum (`IDLE`, `RAMP`, `RUN`, `LOCKOUT`)
  - default cycle constants for 50 MHz
  - `MAX_CH`=8
- Sub-module `level_debounce` (sync + counter), one instance per channel via generate.
- Per-channel FSM, ramp timers and target registers live inline in a generate loop. The PWM counter is shared.

## Test plan
- `NUM_CH`=2, ramp on, `RAMP_STEP_CYCLES`=4: command ch1 duty 8 → `duty_now[1]` goes 1..8, one step every 4 cycles, then RUN. `pwm_out[1]` high for 8 of every 255 cycles.
- Command ch0 duty 255 then duty 0 with ramp compiled out → `pwm_out[0]` constant 1, then constant 0 two cycles after the second accept.
- `NUM_CH`=3, command `cmd_ch`=3 → `cmd_err` one-cycle pulse; all targets unchanged.
- `DEBOUNCE_CYCLES`=16, ch0 running at 100:
  - `stop_async[0]` held for 10 cycles → no lockout.
  - Held for 20 cycles → `lockout[0]`=1 and duty 0 at cycle 19; ch1 unaffected.
- Stop released and debounced → IDLE, `pwm_out[0]` stays 0 until a new command of 50 → ramp to 50.
- Assert `reset` mid-ramp → next edge: all outputs 0 and `cmd_ready`=0. After release, `cmd_ready`=1.

Source files
------------

// File: rtl/multi_pump_pkg.sv
// rtl/multi_pump_pkg.sv - shared types and constants for the multi-channel pump controller
package multi_pump_pkg;

    localparam int MAX_CH                = 8;
    localparam int DEF_DEBOUNCE_CYCLES   = 1_000_000;
    localparam int DEF_RAMP_STEP_CYCLES  = 50_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP    = 2'd1,
        RUN     = 2'd2,
        LOCKOUT = 2'd3
    } ch_state_t;

    // Channel index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_pump_if.sv
// rtl/multi_pump_if.sv - duty command port between status decode and the pump controller
interface multi_pump_if
    import multi_pump_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int PWM_WIDTH = 8
);
    localparam int CH_W = ch_width(NUM_CH);

    logic                 cmd_valid;
    logic [CH_W-1:0]      cmd_ch;
    logic [PWM_WIDTH-1:0] cmd_duty;
    logic                 cmd_ready;
    logic                 cmd_err;

    modport master (
        output cmd_valid, cmd_ch, cmd_duty,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_duty,
        output cmd_ready, cmd_err
    );

endinterface

// File: rtl/level_debounce.sv
// rtl/level_debounce.sv - two-flop synchroniser plus stable-level debouncer
module level_debounce
    import multi_pump_pkg::*;
#(
    parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    localparam int            CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the raw asynchronous level into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has held for CYCLES samples; any bounce restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= 1'b0;
            cnt  <= '0;
        end else if (sync2 == dout) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            dout <= sync2;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multi_pump_ctrl.sv
// rtl/multi_pump_ctrl.sv - N-channel ramped PWM pump controller with interlocks; ramp enabled by MULTI_PUMP_RAMP_EN
module multi_pump_ctrl
    import multi_pump_pkg::*;
#(
    parameter int NUM_CH           = 2,
    parameter int PWM_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int RAMP_STEP_CYCLES = DEF_RAMP_STEP_CYCLES
) (
    input  logic                        clk,
    input  logic                        reset,
    multi_pump_if.slave                 cmd,
    input  logic [NUM_CH-1:0]           stop_async,
    output logic [NUM_CH-1:0]           pwm_out,
    output logic [NUM_CH-1:0]           lockout,
    output logic [NUM_CH*PWM_WIDTH-1:0] duty_now
);
    localparam int                   CH_W     = ch_width(NUM_CH);
    localparam logic [CH_W:0]        CH_LIMIT = (CH_W + 1)'(NUM_CH);
    localparam logic [PWM_WIDTH-1:0] CNT_LAST = PWM_WIDTH'((1 << PWM_WIDTH) - 2);
    // An out-of-range build never raises ready, so it can never act on a command.
    localparam logic CFG_OK = (NUM_CH >= 1) && (NUM_CH <= MAX_CH) &&
                              (RAMP_STEP_CYCLES >= 1) && (DEBOUNCE_CYCLES >= 1);

    logic                 accept;
    logic [PWM_WIDTH-1:0] pwm_cnt;

    assign accept = cmd.cmd_valid && cmd.cmd_ready;

    // Ready in every non-reset cycle; flag commands addressed past the last channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd.cmd_ready <= 1'b0;
            cmd.cmd_err   <= 1'b0;
        end else begin
            cmd.cmd_ready <= CFG_OK;
            cmd.cmd_err   <= accept && ({1'b0, cmd.cmd_ch} >= CH_LIMIT);
        end
    end

    // Shared PWM timebase; stopping one short of all-ones makes full-scale duty a constant high.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == CNT_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);

        logic                 stop_deb;
        logic                 sel;
        logic                 pwm_q;
        logic [PWM_WIDTH-1:0] target;
        logic [PWM_WIDTH-1:0] duty;
        ch_state_t            state;

        assign sel = accept && (cmd.cmd_ch == IDX);

        level_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .din   (stop_async[i]),
            .dout  (stop_deb)
        );

`ifdef MULTI_PUMP_RAMP_EN
        localparam int               STEP_W    = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
        localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEP_CYCLES - 1);

        logic [STEP_W-1:0]    step_cnt;
        logic [PWM_WIDTH-1:0] duty_step;
        logic [PWM_WIDTH-1:0] duty_nx;
        logic                 step_now;

        // One-LSB move toward the target, taken only when the step timer expires.
        always_comb begin
            duty_step = (duty < target) ? duty + 1'b1 : duty - 1'b1;
            step_now  = (duty != target) && !sel && (step_cnt == STEP_LAST);
            duty_nx   = step_now ? duty_step : duty;
        end

        // Channel FSM: a new target restarts the step timer; stop overrides everything.
        always_ff @(posedge clk) begin
            if (reset) begin
                state    <= IDLE;
                target   <= '0;
                duty     <= '0;
                step_cnt <= '0;
            end else if (stop_deb) begin
                state    <= LOCKOUT;
                target   <= '0;
                duty     <= '0;
                step_cnt <= '0;
            end else if (state == LOCKOUT) begin
                state <= IDLE;
            end else begin
                if (sel) begin
                    target   <= cmd.cmd_duty;
                    step_cnt <= '0;
                end else if (duty != target) begin
                    step_cnt <= step_now ? '0 : step_cnt + 1'b1;
                end
                duty  <= duty_nx;
                state <= (duty_nx != target) ? RAMP :
                         ((target == '0) ? IDLE : RUN);
            end
        end
`else
        // Channel FSM without ramping: duty tracks the target one cycle behind.
        always_ff @(posedge clk) begin
            if (reset) begin
                state  <= IDLE;
                target <= '0;
                duty   <= '0;
            end else if (stop_deb) begin
                state  <= LOCKOUT;
                target <= '0;
                duty   <= '0;
            end else if (state == LOCKOUT) begin
                state <= IDLE;
            end else begin
                if (sel) begin
                    target <= cmd.cmd_duty;
                end
                duty  <= target;
                state <= (target == '0) ? IDLE : RUN;
            end
        end
`endif

        // Registered PWM compare; a duty change applies immediately, mid-period.
        always_ff @(posedge clk) begin
            if (reset) begin
                pwm_q <= 1'b0;
            end else begin
                pwm_q <= (pwm_cnt < duty);
            end
        end

        assign pwm_out[i]                          = pwm_q;
        assign lockout[i]                          = (state == LOCKOUT);
        assign duty_now[i*PWM_WIDTH +: PWM_WIDTH]  = duty;
    end

endmodule

// File: tb/tb_multi_pump_ctrl.sv
// tb/tb_multi_pump_ctrl.sv - scoreboard bench for multi_pump_ctrl, both MULTI_PUMP_RAMP_EN builds
module tb_multi_pump_ctrl;

    localparam int NCH  = 3;
    localparam int W    = 8;
    localparam int DEB  = 16;
    localparam int STEP = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NCH-1:0]   stop_async = '0;
    logic [NCH-1:0]   pwm_out;
    logic [NCH-1:0]   lockout;
    logic [NCH*W-1:0] duty_now;

    multi_pump_if #(.NUM_CH(NCH), .PWM_WIDTH(W)) bus ();

    multi_pump_ctrl #(
        .NUM_CH           (NCH),
        .PWM_WIDTH        (W),
        .DEBOUNCE_CYCLES  (DEB),
        .RAMP_STEP_CYCLES (STEP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (bus),
        .stop_async (stop_async),
        .pwm_out    (pwm_out),
        .lockout    (lockout),
        .duty_now   (duty_now)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NCH*W-1:0] v;
        int               t;
    } exp_t;

    exp_t             dq[$];
    int               eq[$];
    int               total = 0;
    int               bad = 0;
    int               model[NCH];
    bit               lk[NCH];
    bit               mon_en = 1'b0;
    logic [NCH*W-1:0] prev;

    function automatic logic [NCH*W-1:0] vec();
        logic [NCH*W-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) r[i*W +: W] = W'(model[i]);
        return r;
    endfunction

    function automatic int settle(input int steps);
`ifdef MULTI_PUMP_RAMP_EN
        return STEP * steps + 8;
`else
        return 8 + 0 * steps;
`endif
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_ramp(input int ch, input int duty, input int a, input int cutoff);
`ifdef MULTI_PUMP_RAMP_EN
        int k;
        k = 0;
        while (model[ch] != duty) begin
            k++;
            model[ch] += (duty > model[ch]) ? 1 : -1;
            if (a + STEP * k < cutoff) dq.push_back('{vec(), a + STEP * k});
        end
`else
        if (model[ch] != duty) begin
            model[ch] = duty;
            if (a + 1 < cutoff) dq.push_back('{vec(), a + 1});
        end
`endif
    endtask

    task automatic send(input int ch, input int duty, input int cutoff = 1 << 30);
        int a;
        a = cyc + 1;
        bus.cmd_valid = 1'b1;
        bus.cmd_ch    = 2'(ch);
        bus.cmd_duty  = 8'(duty);
        if (ch >= NCH) eq.push_back(a);
        else if (!lk[ch]) push_ramp(ch, duty, a, cutoff);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic count_high(input int ch, input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_out[ch]) c++;
        end
    endtask

    // Monitor: every duty_now change and every cmd_err pulse must match the next expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (duty_now !== prev) begin
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL duty_unexpected act=%h prev=%h cyc=%0d", duty_now, prev, cyc);
                end else begin
                    exp_t e;
                    e = dq.pop_front();
                    if (duty_now !== e.v || cyc != e.t) begin
                        bad++;
                        $display("FAIL duty_now act=%h@%0d exp=%h@%0d", duty_now, cyc, e.v, e.t);
                    end
                end
                prev = duty_now;
            end
            if (bus.cmd_err) begin
                total++;
                if (eq.size() == 0) begin
                    bad++;
                    $display("FAIL cmd_err_unexpected cyc=%0d", cyc);
                end else begin
                    int t;
                    t = eq.pop_front();
                    if (cyc != t) begin
                        bad++;
                        $display("FAIL cmd_err_time act=%0d exp=%0d", cyc, t);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int s;
        int r;
        int a2;
        bus.cmd_valid = 1'b0;
        bus.cmd_ch    = '0;
        bus.cmd_duty  = '0;
        for (int i = 0; i < NCH; i++) begin
            model[i] = 0;
            lk[i]    = 1'b0;
        end

        repeat (3) @(negedge clk);
        chk("rst_ready", bus.cmd_ready, 0);
        chk("rst_err", bus.cmd_err, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_lockout", lockout, 0);
        chk("rst_duty", duty_now, 0);
        reset  = 1'b0;
        prev   = duty_now;
        mon_en = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", bus.cmd_ready, 1);

        send(1, 8);
        wait_n(settle(8));
        count_high(1, 255, c);
        chk("pwm1_duty8", c, 8);

        send(0, 255);
        wait_n(settle(255));
        count_high(0, 255, c);
        chk("pwm0_full", c, 255);
        send(0, 0);
`ifndef MULTI_PUMP_RAMP_EN
        wait_to(cyc + 1);
        chk("pwm0_hold", pwm_out[0], 1);
        wait_to(cyc + 1);
        chk("pwm0_off", pwm_out[0], 0);
`endif
        wait_n(settle(255));
        count_high(0, 255, c);
        chk("pwm0_zero", c, 0);

        send(3, 77);
        wait_n(5);

        send(0, 100);
        wait_n(settle(100));
        stop_async[0] = 1'b1;
        wait_n(10);
        stop_async[0] = 1'b0;
        wait_n(30);
        chk("no_lockout_short", lockout, 0);

        s = cyc;
        stop_async[0] = 1'b1;
        model[0] = 0;
        lk[0]    = 1'b1;
        dq.push_back('{vec(), s + 19});
        wait_to(s + 18);
        chk("lockout_pre", lockout, 0);
        wait_to(s + 19);
        chk("lockout_set", lockout, 3'b001);
        wait_to(s + 20);
        chk("pwm0_locked", pwm_out[0], 0);
        r = cyc;
        stop_async[0] = 1'b0;
        send(0, 200);
        wait_to(r + 18);
        chk("lockout_hold", lockout, 3'b001);
        wait_to(r + 19);
        chk("lockout_clear", lockout, 0);
        lk[0] = 1'b0;
        count_high(0, 255, c);
        chk("pwm0_idle_after_lock", c, 0);
        send(0, 50);
        wait_n(settle(50));
        chk("duty0_50", duty_now[W-1:0], 50);

        a2 = cyc + 1;
        send(2, 40, a2 + 10);
        wait_to(a2 + 9);
        reset = 1'b1;
        for (int i = 0; i < NCH; i++) model[i] = 0;
        dq.push_back('{vec(), a2 + 10});
        wait_to(a2 + 10);
        chk("midrst_ready", bus.cmd_ready, 0);
        chk("midrst_pwm", pwm_out, 0);
        chk("midrst_duty", duty_now, 0);
        chk("midrst_lockout", lockout, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_midrst", bus.cmd_ready, 1);

        wait_n(10);
        chk("dq_empty", dq.size(), 0);
        chk("eq_empty", eq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
